mem_port_arbiter: RTL

Sequencer for the single shared RAM port of the five-stage MIPS core. It arbitrates between instruction fetch and the MEM-stage data access, presenting one request at a time to a handshaked RAM. It returns read data to the winning side and stalls each requester until its access completes. It sits between the IF/MEM stages and the unified instruction/data RAM, and consumes the MEM stage's memAddr/wtData/memWr/memCe outputs as its data-side request.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shared RAM port sequencer: arbitrates instruction fetch against MEM-stage data
// accesses (data first), drives a held ram_ce/ram_ack handshake and aborts on timeout.
module mem_port_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_ce,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  input  logic        i_ce,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ram_ce_q, ram_ce_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_done_q, d_done_d;
  logic        i_done_q, i_done_d;
  logic        err_q, err_d;

  logic d_elig, i_elig;
  logic timed_out, finish;
  logic grant_d, grant_i;

  // A side whose done is high this cycle has just been served and is not re-accepted.
  assign d_elig    = d_ce & ~d_done_q;
  assign i_elig    = i_ce & ~i_done_q;
  assign timed_out = (cnt_q == TO_LAST) & ~ram_ack;
  assign finish    = ram_ack | timed_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    d_rdata_d   = d_rdata_q;
    i_rdata_d   = i_rdata_q;
    d_done_d    = 1'b0;
    i_done_d    = 1'b0;
    err_d       = 1'b0;
    grant_d     = 1'b0;
    grant_i     = 1'b0;

    case (state_q)
      IDLE: begin
        grant_d = d_elig;
        grant_i = ~d_elig & i_elig;
      end
      DACC: begin
        if (finish) begin
          d_done_d = 1'b1;
          err_d    = timed_out;
          if (!ram_we_q)
            d_rdata_d = timed_out ? ERR_DATA : ram_rdata;
          grant_i = i_elig;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      IACC: begin
        if (finish) begin
          i_done_d  = 1'b1;
          err_d     = timed_out;
          i_rdata_d = timed_out ? ERR_DATA : ram_rdata;
          grant_d   = d_elig;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grants reload the request registers so ram_ce stays high across back-to-back accesses.
    if (grant_d) begin
      state_d     = DACC;
      cnt_d       = 8'd0;
      ram_ce_d    = 1'b1;
      ram_we_d    = d_we;
      ram_addr_d  = d_addr;
      ram_wdata_d = d_we ? d_wdata : 32'd0;
    end else if (grant_i) begin
      state_d     = IACC;
      cnt_d       = 8'd0;
      ram_ce_d    = 1'b1;
      ram_we_d    = 1'b0;
      ram_addr_d  = i_addr;
      ram_wdata_d = 32'd0;
    end else if (finish && state_q != IDLE) begin
      state_d     = IDLE;
      cnt_d       = 8'd0;
      ram_ce_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = 32'd0;
      ram_wdata_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      d_rdata_q   <= 32'd0;
      i_rdata_q   <= 32'd0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      d_rdata_q   <= d_rdata_d;
      i_rdata_q   <= i_rdata_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      err_q       <= err_d;
    end
  end

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign i_done    = i_done_q;
  assign err       = err_q;
  assign d_stall   = d_ce & ~d_done_q;
  assign i_stall   = i_ce & ~i_done_q;

endmodule
